midi_uart_rx: RTL

MIDI serial receiver: deserialises 8N1 frames (start bit, 8 data bits LSB first, stop bit) from the MIDI IN line and writes each good byte into the downstream receive FIFO. It is the inbound counterpart of the MIDI router's UART transmit path. It runs on the same oversampling clock, with OVERSAMPLE clk cycles per bit time. It sits between the optocoupler input pin and the message parser's FIFO.

---
 rtl/midi_pkg.sv | 20 ++
 rtl/midi_uart_rx_if.sv | 10 +
 rtl/midi_sync2.sv | 28 ++
 rtl/midi_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line-state encodings (common with the TX path),
// baud constant, default oversampling ratio and a 2-of-3 vote helper.
package midi_pkg;

    localparam int unsigned MIDI_BAUD      = 32'd31250;
    localparam int unsigned OVERSAMPLE_DEF = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } midi_state_e;

    // 2-of-3 majority vote used to reject single-cycle line noise
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/midi_uart_rx_if.sv
// Receive-FIFO write port of the MIDI receiver.
// master: the receiver (drives data/strobe), slave: the FIFO (drives ready).
interface midi_uart_rx_if;
    logic [7:0] data_o;
    logic       fifo_wr;
    logic       fifo_full_n;

    modport master (output data_o, output fifo_wr, input  fifo_full_n);
    modport slave  (input  data_o, input  fifo_wr, output fifo_full_n);
endinterface

// File: rtl/midi_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL selects the value both flops take in reset (idle level of the line).
module midi_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver. Oversamples the MIDI IN line, deserialises
// start + 8 data (LSB first) + stop, and writes good bytes to the receive FIFO.
// Build option: define MIDI_RX_MAJORITY_EN to take each bit as a 2-of-3 vote
// around mid-bit (decision one phase later); otherwise a single mid-bit sample.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_i,
    input  logic                  err_clr,
    output logic                  frame_err,
    output logic                  overrun_o,
    output logic                  busy_o,
    midi_uart_rx_if.master        fifo
);

    localparam int unsigned PW = (OVERSAMPLE > 32'd1) ? $clog2(OVERSAMPLE) : 32'd1;

    localparam logic [PW-1:0] PH_ZERO = PW'(32'd0);
    localparam logic [PW-1:0] PH_ONE  = PW'(32'd1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 32'd1);
    localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 32'd2);
`ifdef MIDI_RX_MAJORITY_EN
    localparam logic [PW-1:0] PH_PRE  = PW'(OVERSAMPLE / 32'd2 - 32'd1);
    localparam logic [PW-1:0] PH_DEC  = PW'(OVERSAMPLE / 32'd2 + 32'd1);
`else
    localparam logic [PW-1:0] PH_DEC  = PH_MID;
`endif

    // synchronised line and the bit value used at the decision phase
    logic w_rx_s;
    logic w_bit;

    // state and datapath registers
    midi_state_e   r_state;
    logic [PW-1:0] r_phase;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_brk;
    logic [7:0]    r_data;
    logic          r_wr;
    logic          r_ferr;
    logic          r_ovr;
    logic          r_busy;

    // next-state values
    midi_state_e   w_state_nxt;
    logic [PW-1:0] w_phase_nxt;
    logic [2:0]    w_bitcnt_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_brk_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_wr_nxt;
    logic          w_ferr_nxt;
    logic          w_ovr_nxt;
    logic          w_busy_nxt;

    midi_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_i),
        .o_q   (w_rx_s)
    );

`ifdef MIDI_RX_MAJORITY_EN
    logic r_smp_pre;
    logic r_smp_mid;

    // Hold the two early votes; the third vote is the live line at PH_DEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_smp_pre <= 1'b1;
            r_smp_mid <= 1'b1;
        end else begin
            if (r_phase == PH_PRE) begin
                r_smp_pre <= w_rx_s;
            end
            if (r_phase == PH_MID) begin
                r_smp_mid <= w_rx_s;
            end
        end
    end

    assign w_bit = maj3(r_smp_pre, r_smp_mid, w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_ZERO;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_brk    <= 1'b0;
            r_data   <= 8'h00;
            r_wr     <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_brk    <= w_brk_nxt;
            r_data   <= w_data_nxt;
            r_wr     <= w_wr_nxt;
            r_ferr   <= w_ferr_nxt;
            r_ovr    <= w_ovr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Frame sequencing: start check, data shift, stop decision and break wait
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = (r_phase == PH_LAST) ? PH_ZERO : (r_phase + PH_ONE);
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_brk_nxt    = r_brk;
        w_data_nxt   = r_data;
        w_wr_nxt     = 1'b0;
        w_ferr_nxt   = 1'b0;
        // a new overrun below overrides this clear
        w_ovr_nxt    = r_ovr & ~err_clr;

        case (r_state)
            ST_IDLE: begin
                w_brk_nxt = 1'b0;
                if (!w_rx_s) begin
                    // the detect cycle is start-bit phase 0
                    w_state_nxt = ST_START;
                    w_phase_nxt = PH_ONE;
                end else begin
                    w_phase_nxt = PH_ZERO;
                end
            end

            ST_START: begin
                if ((r_phase == PH_DEC) && w_bit) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = PH_ZERO;
                end else if (r_phase == PH_LAST) begin
                    w_state_nxt  = ST_DATA;
                    w_bitcnt_nxt = 3'd0;
                end else begin
                    w_state_nxt = ST_START;
                end
            end

            ST_DATA: begin
                if (r_phase == PH_DEC) begin
                    w_shift_nxt = {w_bit, r_shift[7:1]};
                end else begin
                    w_shift_nxt = r_shift;
                end
                if (r_phase == PH_LAST) begin
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end else begin
                    w_bitcnt_nxt = r_bitcnt;
                end
            end

            ST_STOP: begin
                if (r_brk) begin
                    // framing error seen: wait for the line to return high so
                    // a held break cannot look like a new start bit
                    if (w_rx_s) begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = PH_ZERO;
                        w_brk_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_STOP;
                    end
                end else if (r_phase == PH_DEC) begin
                    if (w_bit) begin
                        // leave at the decision so the next start edge resyncs
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = PH_ZERO;
                        if (fifo.fifo_full_n) begin
                            w_data_nxt = r_shift;
                            w_wr_nxt   = 1'b1;
                        end else begin
                            w_ovr_nxt  = 1'b1;
                        end
                    end else begin
                        w_ferr_nxt = 1'b1;
                        w_brk_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = PH_ZERO;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign fifo.data_o  = r_data;
    assign fifo.fifo_wr = r_wr;
    assign frame_err    = r_ferr;
    assign overrun_o    = r_ovr;
    assign busy_o       = r_busy;

endmodule
